// File: rtl/uart_pkg.sv
// uart_pkg: UART state encoding and framing constants shared by uart_rx and uart_tx
package uart_pkg;
  localparam int CLKS_PER_BIT_DEF = 434;
  localparam int DATA_BITS = 8;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} uart_state_t;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the serial line, resets to the idle level
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta_q;
  always_ff @(posedge clk) begin
    if (rst) {q, meta_q} <= 2'b11;
    else     {q, meta_q} <= {meta_q, d};
  end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with one-byte valid/ready output buffer
// Define UART_RX_PARITY_EN to add an even-parity bit and the rx_parity_err output.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       rx_clk,
  input  logic       rx_rst,
  input  logic       rx_input,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_frame_err,
  output logic       rx_overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic       rx_parity_err
`endif
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
`ifdef UART_RX_PARITY_EN
  localparam uart_state_t AFTER_DATA = PARITY;
`else
  localparam uart_state_t AFTER_DATA = STOP;
`endif
  uart_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
  logic valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d, rx_s, tick;
`ifdef UART_RX_PARITY_EN
  logic perr_q, perr_d, par_bad_q, par_bad_d;
`endif
  uart_rx_sync u_sync (.clk(rx_clk), .rst(rx_rst), .d(rx_input), .q(rx_s));
  assign tick = cnt_q == LAST;
  always_comb begin
    state_d = state_q;
    cnt_d   = tick ? '0 : cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q & ~rx_ready;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d    = 1'b0;
    par_bad_d = par_bad_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        state_d = rx_s ? IDLE : START;
      end
      START: if (cnt_q == HALF) begin
        cnt_d   = '0;
        bit_d   = '0;
        state_d = rx_s ? IDLE : DATA;
      end
      DATA: if (tick) begin
        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
        bit_d   = bit_q + 1'b1;
        state_d = bit_q == 3'd7 ? AFTER_DATA : DATA;
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (tick) begin
        par_bad_d = ^{shift_q, rx_s};
        state_d   = STOP;
      end
`endif
      STOP: if (tick) begin
        state_d = rx_s ? IDLE : BREAK;
        ferr_d  = ~rx_s;
        if (rx_s) begin
`ifdef UART_RX_PARITY_EN
          if (par_bad_q) perr_d = 1'b1;
          else
`endif
          if (!valid_q || rx_ready) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else ovr_d = 1'b1;
        end
      end
      BREAK: begin
        cnt_d   = '0;
        state_d = rx_s ? IDLE : BREAK;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end
`ifdef UART_RX_PARITY_EN
  always_ff @(posedge rx_clk) begin
    if (rx_rst) {perr_q, par_bad_q} <= 2'b00;
    else        {perr_q, par_bad_q} <= {perr_d, par_bad_d};
  end
  assign rx_parity_err = perr_q;
`endif
  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = ferr_q;
  assign rx_overrun   = ovr_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx (honours UART_RX_PARITY_EN)
module tb_uart_rx;
  localparam int CPB = 434;
`ifdef UART_RX_PARITY_EN
  localparam int NPAR = 1;
`else
  localparam int NPAR = 0;
`endif
  localparam int STOP_EDGE = CPB / 2 + 3 + (9 + NPAR) * CPB;
  logic rx_clk = 1'b0, rx_rst = 1'b1, rx_input = 1'b1, rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic rx_valid, rx_frame_err, rx_overrun;
  int tests = 0, fails = 0;
  int xfer_cnt = 0, ferr_cnt = 0, ovr_cnt = 0, perr_cnt = 0, vlow_cnt = 0;
  logic [7:0] last_xfer = 8'h00;
  int x0, f0, o0, p0, v0;
`ifdef UART_RX_PARITY_EN
  logic rx_parity_err;
`endif
  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .rx_clk(rx_clk), .rx_rst(rx_rst), .rx_input(rx_input), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_frame_err(rx_frame_err),
    .rx_overrun(rx_overrun)
`ifdef UART_RX_PARITY_EN
    , .rx_parity_err(rx_parity_err)
`endif
  );
  always #5 rx_clk = ~rx_clk;
  always @(negedge rx_clk) begin
    if (rx_valid && rx_ready) begin
      xfer_cnt  <= xfer_cnt + 1;
      last_xfer <= rx_data;
    end
    if (rx_frame_err) ferr_cnt <= ferr_cnt + 1;
    if (rx_overrun) ovr_cnt <= ovr_cnt + 1;
    if (!rx_valid) vlow_cnt <= vlow_cnt + 1;
`ifdef UART_RX_PARITY_EN
    if (rx_parity_err) perr_cnt <= perr_cnt + 1;
`endif
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge rx_clk);
    #1;
  endtask
  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
    rx_input = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_input = b[i];
      tick(CPB);
    end
    if (NPAR == 1) begin
      rx_input = par;
      tick(CPB);
    end
    rx_input = stop;
    tick(CPB);
    rx_input = 1'b1;
  endtask
  task automatic snap();
    x0 = xfer_cnt; f0 = ferr_cnt; o0 = ovr_cnt; p0 = perr_cnt; v0 = vlow_cnt;
  endtask
  initial begin
    tick(5);
    rx_rst = 1'b0;
    tick(1);
    check("reset_valid", 32'(rx_valid), 0);
    check("reset_data", 32'(rx_data), 0);
    check("reset_ferr", 32'(rx_frame_err), 0);
    check("reset_ovr", 32'(rx_overrun), 0);
    tick(CPB);
    snap();
    send_frame(8'h72, ^8'h72, 1'b1);
    tick(CPB);
    check("b72_count", 32'(xfer_cnt - x0), 1);
    check("b72_data", 32'(last_xfer), 32'h72);
    check("b72_errs", 32'(ferr_cnt - f0 + ovr_cnt - o0 + perr_cnt - p0), 0);
    snap();
    rx_input = 1'b0;
    tick(100);
    rx_input = 1'b1;
    tick(1000);
    check("glitch_valid", 32'(xfer_cnt - x0), 0);
    check("glitch_ferr", 32'(ferr_cnt - f0), 0);
    send_frame(8'hA5, ^8'hA5, 1'b1);
    tick(CPB);
    check("bA5_count", 32'(xfer_cnt - x0), 1);
    check("bA5_data", 32'(last_xfer), 32'hA5);
    snap();
    send_frame(8'h55, ^8'h55, 1'b0);
    rx_input = 1'b0;
    tick(2000);
    rx_input = 1'b1;
    tick(CPB);
    check("break_ferr", 32'(ferr_cnt - f0), 1);
    check("break_valid", 32'(xfer_cnt - x0), 0);
    send_frame(8'h3C, ^8'h3C, 1'b1);
    tick(CPB);
    check("b3C_data", 32'(last_xfer), 32'h3C);
    check("b3C_count", 32'(xfer_cnt - x0), 1);
    rx_ready = 1'b0;
    snap();
    send_frame(8'h11, ^8'h11, 1'b1);
    tick(CPB);
    send_frame(8'h22, ^8'h22, 1'b1);
    tick(CPB);
    check("ovr_valid", 32'(rx_valid), 1);
    check("ovr_data", 32'(rx_data), 32'h11);
    check("ovr_pulse", 32'(ovr_cnt - o0), 1);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    check("ovr_drain_valid", 32'(rx_valid), 0);
    check("ovr_drain_data", 32'(last_xfer), 32'h11);
    send_frame(8'h11, ^8'h11, 1'b1);
    tick(CPB);
    snap();
    fork
      send_frame(8'h22, ^8'h22, 1'b1);
      begin
        tick(STOP_EDGE - 1);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
      end
    join
    tick(CPB);
    check("same_cycle_valid", 32'(rx_valid), 1);
    check("same_cycle_data", 32'(rx_data), 32'h22);
    check("same_cycle_no_ovr", 32'(ovr_cnt - o0), 0);
    check("same_cycle_valid_held", 32'(vlow_cnt - v0), 0);
    check("same_cycle_xfer", 32'(last_xfer), 32'h11);
    snap();
    fork
      send_frame(8'hFF, ^8'hFF, 1'b1);
      begin
        tick(2300);
        rx_rst = 1'b1;
        tick(1);
        check("rst_outputs", 32'({rx_valid, rx_data, rx_frame_err, rx_overrun}), 0);
        tick(1);
        rx_rst = 1'b0;
      end
    join
    tick(CPB);
    check("rst_no_byte", 32'(rx_valid), 0);
    rx_ready = 1'b1;
    send_frame(8'h81, ^8'h81, 1'b1);
    tick(CPB);
    check("b81_data", 32'(last_xfer), 32'h81);
    check("b81_count", 32'(xfer_cnt - x0), 1);
`ifdef UART_RX_PARITY_EN
    snap();
    send_frame(8'h07, 1'b0, 1'b1);
    tick(CPB);
    check("par_err_pulse", 32'(perr_cnt - p0), 1);
    check("par_no_valid", 32'(xfer_cnt - x0), 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
